// File: rtl/oam_scan_pkg.sv
// Shared constants and state type for the per-line OAM scan sequencer.
//   NUM_OAM      entries walked per line
//   MAX_SPRITES  sprite-store slots filled per line
//   Y_OFFSET     OAM Y is stored biased by 16 lines
//   SPR_H_*      sprite heights for LCDC obj_size = 0 / 1
package oam_scan_pkg;

   localparam int NUM_OAM     = 40;
   localparam int MAX_SPRITES = 10;
   localparam int Y_OFFSET    = 16;
   localparam int SPR_H_SMALL = 8;
   localparam int SPR_H_TALL  = 16;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/sprite_y_match.sv
// Combinational Y-range test of one OAM entry against the current line.
//   v        current line (LY)
//   oam_y    OAM byte 0 (Y + 16)
//   obj_size 0 = 8-line, 1 = 16-line sprites
//   hit      line v falls inside the sprite
//   line     row within the sprite when hit
module sprite_y_match
   import oam_scan_pkg::*;
(
   input  logic [7:0] v,
   input  logic [7:0] oam_y,
   input  logic       obj_size,
   output logic       hit,
   output logic [3:0] line
);

   logic [8:0] diff;
   logic [8:0] height;

   // 9-bit two's complement: bit 8 set means the sprite starts below line v.
   // Wrap of v+16 past 255 only happens where the true difference is already
   // far outside any sprite height, so it can never produce a false hit.
   assign diff   = {1'b0, v} + 9'(Y_OFFSET) - {1'b0, oam_y};
   assign height = obj_size ? 9'(SPR_H_TALL) : 9'(SPR_H_SMALL);
   assign hit    = !diff[8] && (diff < height);
   assign line   = diff[3:0];

endmodule

// File: rtl/oam_scan_ctrl.sv
// Mode-2 OAM scan sequencer. Walks all OAM entries two dots each (address,
// then compare), writes up to MAX_SPRITES hits into the sprite store and
// reports the hit count to the fetch side.
//   clk1, nreset_video       dot clock, async active-low reset
//   line_start               starts (or restarts) a scan
//   obj_size, v, dma_active  compare controls, sampled at each compare
//   oam_y, oam_x             addressed entry bytes
//   busy, oam_rd, oam_addr   OAM read port ownership
//   store_*                  sprite-store write port
//   sprite_count, scan_done  result handed to the fetch side
//
// state | meaning
// IDLE  | waiting for line_start; sprite_count holds last result
// SCAN  | walking entries; phase_q 0 = address dot, 1 = compare dot
module oam_scan_ctrl #(
   parameter int NUM_OAM     = oam_scan_pkg::NUM_OAM,
   parameter int MAX_SPRITES = oam_scan_pkg::MAX_SPRITES
) (
   input  logic       clk1,
   input  logic       nreset_video,
   input  logic       line_start,
   input  logic       obj_size,
   input  logic [7:0] v,
   input  logic       dma_active,
   input  logic [7:0] oam_y,
   input  logic [7:0] oam_x,
   output logic       busy,
   output logic       oam_rd,
   output logic [5:0] oam_addr,
   output logic       store_we,
   output logic [3:0] store_slot,
   output logic [5:0] store_index,
   output logic [3:0] store_line,
   output logic [7:0] store_x,
   output logic [3:0] sprite_count,
   output logic       scan_done
);

   import oam_scan_pkg::*;

   localparam logic [5:0] LAST_IDX = 6'(NUM_OAM - 1);
   localparam logic [3:0] MAX_CNT  = 4'(MAX_SPRITES);

   state_t     state_q, state_d;
   logic [5:0] idx_q, idx_d;
   logic       phase_q, phase_d;
   logic [3:0] count_q, count_d;
   logic       store_we_q, store_we_d;
   logic [3:0] store_slot_q, store_slot_d;
   logic [5:0] store_index_q, store_index_d;
   logic [3:0] store_line_q, store_line_d;
   logic [7:0] store_x_q, store_x_d;
   logic       scan_done_q, scan_done_d;

   logic       y_hit;
   logic [3:0] y_line;

   sprite_y_match u_y_match (
      .v        (v),
      .oam_y    (oam_y),
      .obj_size (obj_size),
      .hit      (y_hit),
      .line     (y_line)
   );

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      phase_d       = phase_q;
      count_d       = count_q;
      store_we_d    = 1'b0;
      store_slot_d  = store_slot_q;
      store_index_d = store_index_q;
      store_line_d  = store_line_q;
      store_x_d     = store_x_q;
      scan_done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (line_start) begin
               state_d = SCAN;
               idx_d   = '0;
               phase_d = 1'b0;
               count_d = '0;
            end
         end
         SCAN: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               if (y_hit && !dma_active && (count_q < MAX_CNT)) begin
                  store_we_d    = 1'b1;
                  store_slot_d  = count_q;
                  store_index_d = idx_q;
                  store_line_d  = y_line;
                  store_x_d     = oam_x;
                  count_d       = count_q + 4'd1;
               end
               phase_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d     = IDLE;
                  idx_d       = '0;
                  scan_done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
            // Restart wins over the walk, but a write captured on this same
            // edge is left in place so the store still sees it.
            if (line_start) begin
               state_d     = SCAN;
               idx_d       = '0;
               phase_d     = 1'b0;
               count_d     = '0;
               scan_done_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk1 or negedge nreset_video) begin
      if (!nreset_video) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         phase_q       <= 1'b0;
         count_q       <= '0;
         store_we_q    <= 1'b0;
         store_slot_q  <= '0;
         store_index_q <= '0;
         store_line_q  <= '0;
         store_x_q     <= '0;
         scan_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         phase_q       <= phase_d;
         count_q       <= count_d;
         store_we_q    <= store_we_d;
         store_slot_q  <= store_slot_d;
         store_index_q <= store_index_d;
         store_line_q  <= store_line_d;
         store_x_q     <= store_x_d;
         scan_done_q   <= scan_done_d;
      end
   end

   assign busy         = (state_q == SCAN);
   assign oam_rd       = (state_q == SCAN);
   assign oam_addr     = idx_q;
   assign store_we     = store_we_q;
   assign store_slot   = store_slot_q;
   assign store_index  = store_index_q;
   assign store_line   = store_line_q;
   assign store_x      = store_x_q;
   assign sprite_count = count_q;
   assign scan_done    = scan_done_q;

endmodule

// File: tb/tb_oam_scan_ctrl.sv
module tb_oam_scan_ctrl;

   logic       clk1;
   logic       nreset_video;
   logic       line_start;
   logic       obj_size;
   logic [7:0] v;
   logic       dma_active;
   logic [7:0] oam_y;
   logic [7:0] oam_x;
   logic       busy;
   logic       oam_rd;
   logic [5:0] oam_addr;
   logic       store_we;
   logic [3:0] store_slot;
   logic [5:0] store_index;
   logic [3:0] store_line;
   logic [7:0] store_x;
   logic [3:0] sprite_count;
   logic       scan_done;

   oam_scan_ctrl dut (
      .clk1         (clk1),
      .nreset_video (nreset_video),
      .line_start   (line_start),
      .obj_size     (obj_size),
      .v            (v),
      .dma_active   (dma_active),
      .oam_y        (oam_y),
      .oam_x        (oam_x),
      .busy         (busy),
      .oam_rd       (oam_rd),
      .oam_addr     (oam_addr),
      .store_we     (store_we),
      .store_slot   (store_slot),
      .store_index  (store_index),
      .store_line   (store_line),
      .store_x      (store_x),
      .sprite_count (sprite_count),
      .scan_done    (scan_done)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   // OAM contents seen by the scanner
   logic [7:0] mem_y [40];
   logic [7:0] mem_x [40];

   always_comb begin
      oam_y = 8'hff;
      oam_x = 8'hff;
      if (int'(oam_addr) < 40) begin
         oam_y = mem_y[int'(oam_addr)];
         oam_x = mem_x[int'(oam_addr)];
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      int cyc;
      int seg;
      int slot;
      int idx;
      int line;
      int x;
   } wr_t;

   wr_t exp_q[$];

   // Row within sprite for line v, or -1 when the line misses the sprite.
   function automatic int sprite_row(input int line_v, input int y, input bit tall);
      int d;
      d = line_v - (y - 16);
      if (d >= 0 && d < (tall ? 16 : 8)) return d;
      return -1;
   endfunction

   // Expected writes for a scan whose line_start lands on cycle base, keeping
   // only writes that appear no later than cycle limit.
   task automatic build(input int base, input int limit, input int seg);
      int nhit;
      int r;
      wr_t w;
      nhit = 0;
      for (int k = 0; k < 40; k++) begin
         r = sprite_row(int'(v), int'(mem_y[k]), obj_size);
         if (r >= 0 && !dma_active && nhit < 10) begin
            w.cyc  = base + 2 * k + 2;
            w.seg  = seg;
            w.slot = nhit;
            w.idx  = k;
            w.line = r;
            w.x    = int'(mem_x[k]);
            if (w.cyc <= limit) exp_q.push_back(w);
            nhit++;
         end
      end
   endtask

   // Cycle 0 is the cycle right after the edge that samples line_start.
   // abort_at > 0 re-pulses line_start so it is sampled at edge E(abort_at).
   task automatic run_scan(input int abort_at);
      int n_cyc;
      int base;
      int rel;
      int seg;
      int cnt;
      bit exp_busy;
      bit exp_we;
      wr_t w;
      exp_q.delete();
      if (abort_at > 0) begin
         build(0, abort_at, 0);
         build(abort_at, 100000, 1);
         n_cyc = abort_at + 81;
      end else begin
         build(0, 100000, 0);
         n_cyc = 81;
      end
      cnt = 0;
      line_start = 1'b1;
      @(negedge clk1);
      line_start = 1'b0;
      for (int c = 0; c < n_cyc; c++) begin
         seg  = (abort_at > 0 && c >= abort_at) ? 1 : 0;
         base = seg ? abort_at : 0;
         rel  = c - base;
         if (seg == 1 && c == abort_at) cnt = 0;
         exp_busy = (rel < 80);
         exp_we   = (exp_q.size() > 0) && (exp_q[0].cyc == c);
         chk($sformatf("busy c%0d", c), int'(busy), int'(exp_busy));
         chk($sformatf("oam_rd c%0d", c), int'(oam_rd), int'(exp_busy));
         chk($sformatf("oam_addr c%0d", c), int'(oam_addr), exp_busy ? rel / 2 : 0);
         chk($sformatf("store_we c%0d", c), int'(store_we), int'(exp_we));
         chk($sformatf("scan_done c%0d", c), int'(scan_done), int'(rel == 80));
         if (exp_we) begin
            w = exp_q.pop_front();
            chk($sformatf("store_slot c%0d", c), int'(store_slot), w.slot);
            chk($sformatf("store_index c%0d", c), int'(store_index), w.idx);
            chk($sformatf("store_line c%0d", c), int'(store_line), w.line);
            chk($sformatf("store_x c%0d", c), int'(store_x), w.x);
            if (w.seg == seg) cnt++;
         end
         chk($sformatf("sprite_count c%0d", c), int'(sprite_count), cnt);
         line_start = (abort_at > 0 && c == abort_at - 1);
         @(negedge clk1);
      end
      line_start = 1'b0;
      chk("writes left", exp_q.size(), 0);
      repeat (3) begin
         chk("idle busy", int'(busy), 0);
         chk("idle store_we", int'(store_we), 0);
         chk("idle count hold", int'(sprite_count), cnt);
         @(negedge clk1);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " oam_rd"}, int'(oam_rd), 0);
      chk({tag, " oam_addr"}, int'(oam_addr), 0);
      chk({tag, " store_we"}, int'(store_we), 0);
      chk({tag, " store_slot"}, int'(store_slot), 0);
      chk({tag, " store_index"}, int'(store_index), 0);
      chk({tag, " store_line"}, int'(store_line), 0);
      chk({tag, " store_x"}, int'(store_x), 0);
      chk({tag, " sprite_count"}, int'(sprite_count), 0);
      chk({tag, " scan_done"}, int'(scan_done), 0);
   endtask

   task automatic fill_y(input int y);
      for (int k = 0; k < 40; k++) begin
         mem_y[k] = 8'(y);
         mem_x[k] = 8'($urandom_range(0, 255));
      end
   endtask

   initial begin
      nreset_video = 1'b0;
      line_start   = 1'b0;
      obj_size     = 1'b0;
      v            = 8'd0;
      dma_active   = 1'b0;
      fill_y(0);
      repeat (3) @(negedge clk1);
      check_all_zero("reset");
      nreset_video = 1'b1;
      @(negedge clk1);
      check_all_zero("post-reset");

      // single hit at entry 0, X = 0 still stored
      fill_y(0);
      mem_y[0] = 8'd16;
      mem_x[0] = 8'd0;
      v = 8'd0;
      obj_size = 1'b0;
      run_scan(0);

      // tall sprites, including the last row of a 16-line sprite
      fill_y(0);
      mem_y[3] = 8'd30;
      mem_y[5] = 8'd21;
      mem_y[7] = 8'd30;
      mem_x[7] = 8'd170;
      v = 8'd20;
      obj_size = 1'b1;
      run_scan(0);
      obj_size = 1'b0;
      run_scan(0);

      // saturation at 10 sprites
      fill_y(16);
      v = 8'd0;
      run_scan(0);

      // DMA owns OAM: no matches
      dma_active = 1'b1;
      run_scan(0);
      dma_active = 1'b0;

      // restart mid-scan on a compare edge
      for (int k = 0; k < 40; k++) begin
         mem_y[k] = 8'(($urandom_range(0, 2) == 0) ? 8'd16 : 8'd100);
         mem_x[k] = 8'($urandom_range(0, 255));
      end
      run_scan(30);

      // async reset mid-scan with writes pending every compare
      fill_y(16);
      line_start = 1'b1;
      @(negedge clk1);
      line_start = 1'b0;
      repeat (40) @(negedge clk1);
      nreset_video = 1'b0;
      #1;
      check_all_zero("async rst");
      @(negedge clk1);
      check_all_zero("held rst");
      nreset_video = 1'b1;
      @(negedge clk1);
      check_all_zero("released rst");
      run_scan(0);

      // randomized lines
      for (int n = 0; n < 14; n++) begin
         v = 8'($urandom_range(0, 160));
         obj_size = 1'($urandom_range(0, 1));
         dma_active = ($urandom_range(0, 7) == 0);
         for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0)
               mem_y[k] = 8'($urandom_range(0, 255));
            else
               mem_y[k] = 8'(int'(v) + 16 - int'($urandom_range(0, 17)));
            mem_x[k] = 8'($urandom_range(0, 255));
         end
         if ($urandom_range(0, 3) == 0)
            run_scan(int'($urandom_range(1, 79)));
         else
            run_scan(0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/oam_scan_ctrl.md
# oam_scan_ctrl

Sequencer for the per-line OAM scan (mode 2) feeding the sprite store. On each line start it walks all 40 OAM entries in 80 dots, compares each entry's Y against the current line `v`, and writes up to 10 hits (OAM index, line-within-sprite, X) into successive sprite-store slots. It owns the OAM read port during the scan and hands the resulting sprite count to the fetch side.

## Interface
Parameters:
- `NUM_OAM`, 40: OAM entries scanned per line.
- `MAX_SPRITES`, 10: sprite-store slots.

Ports:
- `clk1`  in  1  dot clock; all state changes on rising edge.
- `nreset_video`  in  1  asynchronous, active-low reset.
- `line_start`  in  1  one-cycle pulse that starts a scan.
- `obj_size`  in  1  LCDC bit 2 (ff40_d2): 0 = 8-line, 1 = 16-line sprites.
- `v`  in  8  current line number (LY).
- `dma_active`  in  1  OAM DMA owns OAM; entries read while high never match.
- `oam_y`  in  8  OAM byte 0 of addressed entry, valid in phase 1.
- `oam_x`  in  8  OAM byte 1 of addressed entry, valid in phase 1.
- `busy`  out  1  scan in progress.
- `oam_rd`  out  1  OAM read strobe.
- `oam_addr`  out  6  entry index 0..39.
- `store_we`  out  1  sprite-store write pulse.
- `store_slot`  out  4  slot 0..9.
- `store_index`  out  6  OAM index of hit.
- `store_line`  out  4  row within sprite (0..15).
- `store_x`  out  8  sprite X.
- `sprite_count`  out  4  hits this line, 0..10.
- `scan_done`  out  1  one-cycle pulse at scan end.

## Operation
- States: IDLE, SCAN. Per-entry phase bit: P0 = address, P1 = compare.
- IDLE: `line_start`=1 → SCAN, idx=0, phase P0, count=0.
- SCAN P0: `oam_rd`=1, `oam_addr`=idx. Next P1.
- SCAN P1: `oam_rd`=1, `oam_addr`=idx; compare `oam_y`. Then idx+1, P0; after idx 39 P1 → IDLE.
- Match: diff = {0,v} + 16 − {0,oam_y}, 9-bit two's complement; hit iff diff ≥ 0 and diff < (obj_size ? 16 : 8). `store_line` = diff[3:0]. X is not filtered (X=0 and X≥168 are stored).
- Hit with count < 10 and `dma_active`=0: register store_we=1, slot=count, index=idx, line, x; count+1. Hit with count = 10: ignored, count saturates.
- `line_start` during SCAN: abort and restart (idx=0, count=0); a write pending from the edge is still emitted.
- `obj_size` and `v` are sampled at each P1 compare.

## Timing
- Reset values: busy=0, oam_rd=0, oam_addr=0, store_we=0, store_slot=0, store_index=0, store_line=0, store_x=0, sprite_count=0, scan_done=0.
- `line_start` sampled at edge E0. busy=1 and oam_rd=1 for cycles E0..E80, exactly 80 cycles. Entry k is addressed on cycles 2k and 2k+1 after E0 and compared at edge E(2k+2).
- `store_we` goes high for one cycle after the compare edge. Latency from entry address to write is 2 cycles.
- `scan_done` is high for the one cycle after E80, the same cycle as entry 39's store_we. `sprite_count` is final by then and holds until the next `line_start`.
- Async reset mid-scan: immediate IDLE, all outputs return to reset values, and no write is emitted.

## Structure
- Package `oam_scan_pkg`: NUM_OAM, MAX_SPRITES, Y_OFFSET=16, SPR_H_SMALL=8, SPR_H_TALL=16, and a state enum {IDLE, SCAN}.
- Sub-module `sprite_y_match`: combinational (v, oam_y, obj_size) → hit, line[3:0].
- The top level holds the FSM, idx/phase counters, the count saturator and the output registers.

## Test plan
- v=0, obj_size=0, entry 0 Y=16, all others Y=0 → one write: slot 0, index 0, line 0. sprite_count=1. scan_done 81 cycles after line_start.
- v=20, obj_size=1, entries 3 and 7 at Y=30, entry 5 at Y=21 → writes for index 3 (line 6), 5 (line 15), 7 (line 6) in slots 0,1,2. Y=21 with obj_size=0 gives no hit for index 5.
- All 40 entries Y=16, v=0 → exactly 10 writes for indices 0..9 on slots 0..9. sprite_count=10, no further store_we.
- dma_active=1 throughout, all entries matching → zero writes, sprite_count=0, busy still high for 80 cycles.
- line_start again at cycle 30 → scan restarts at idx 0, count cleared, busy stays high through cycle 110.
- nreset_video low at cycle 40 of a scan → all outputs 0 asynchronously. A line_start after release gives a normal scan.
